mic1_mem_bridge: RTL

//   Memory-side bridge directly downstream of the MIC-1 CPU core's MAR/MDR port.
//   - Takes one word read or write request at a time (12-bit address, 16-bit data).
//   - Serializes it onto the 8-bit external bus (uo/uio pins) as four byte phases.
//   - Each phase uses a 4-phase strobe/ack handshake.
//   - Returns read data, or an error on handshake timeout.

---
 rtl/mic1_mem_bridge.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mic1_mem_bridge.sv
// Bridge from the MIC-1 MAR/MDR port to an 8-bit strobe/ack bus: each word
// transfer goes out as four byte phases (CMD, ADDR, DHI, DLO), each one a 4-phase handshake.
//   state  | meaning
//   IDLE   | waiting for a request, req_ready high
//   CMD    | {we, 000, addr[11:8]} phase
//   ADDR   | addr[7:0] phase
//   DHI    | data high byte (driven on write, captured on read)
//   DLO    | data low byte
//   RESP   | one-cycle response pulse
module mic1_mem_bridge #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [7:0]        bus_out,
  output logic              bus_oe,
  output logic              bus_strobe,
  input  logic [7:0]        bus_in,
  input  logic              bus_ack,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DHI, S_DLO, S_RESP
  } state_t;

  state_t              state_q, state_d, phase_next;
  logic                rel_q, rel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                in_phase, ack_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rel_q       <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rel_q       <= rel_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rel_d       = rel_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_rdata_d = rsp_rdata_q;
    // STB waits for ack high, REL waits for ack low
    ack_seen    = rel_q ? !bus_ack : bus_ack;

    case (state_q)
      S_CMD:   phase_next = S_ADDR;
      S_ADDR:  phase_next = S_DHI;
      S_DHI:   phase_next = S_DLO;
      default: phase_next = S_RESP;
    endcase

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_CMD;
          rel_d   = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b0;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
        end
      end
      S_CMD, S_ADDR, S_DHI, S_DLO: begin
        if (ack_seen) begin
          cnt_d = '0;
          if (!rel_q) begin
            rel_d = 1'b1;
            if (!we_q && state_q == S_DHI) rdata_d[DATA_W-1 -: 8] = bus_in;
            if (!we_q && state_q == S_DLO) rdata_d[7:0] = bus_in;
          end else begin
            rel_d   = 1'b0;
            state_d = phase_next;
            if (!we_q && state_q == S_DLO) rsp_rdata_d = rdata_q;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_RESP;
          rel_d   = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b1;
          if (!we_q) rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_phase   = (state_q == S_CMD) || (state_q == S_ADDR) ||
                 (state_q == S_DHI) || (state_q == S_DLO);
    req_ready  = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    rsp_valid  = (state_q == S_RESP);
    rsp_err    = (state_q == S_RESP) && err_q;
    rsp_rdata  = rsp_rdata_q;
    bus_strobe = in_phase && !rel_q;
    bus_oe     = 1'b0;
    bus_out    = 8'h00;
    case (state_q)
      S_CMD: begin
        bus_oe  = 1'b1;
        bus_out = {we_q, 3'b000, addr_q[ADDR_W-1 -: 4]};
      end
      S_ADDR: begin
        bus_oe  = 1'b1;
        bus_out = addr_q[7:0];
      end
      S_DHI: begin
        bus_oe  = we_q;
        bus_out = we_q ? wdata_q[DATA_W-1 -: 8] : 8'h00;
      end
      S_DLO: begin
        bus_oe  = we_q;
        bus_out = we_q ? wdata_q[7:0] : 8'h00;
      end
      default: ;
    endcase
  end

endmodule
